// File: rtl/seq_adder_sub.sv
`default_nettype none
// ============================================================================
// Module   : seq_adder_sub
// Purpose  : Multi-cycle adder/subtractor, CHUNK bits per clock with a
//            carried chunk-to-chunk carry, start/done handshake and flags.
// Revision : 1.0 - initial release
// ============================================================================
module seq_adder_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int c_nchunks = WIDTH / CHUNK;
    localparam int c_cntw    = $clog2(c_nchunks + 1);
    localparam logic [c_cntw-1:0] c_last = c_cntw'(c_nchunks - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_accept;
    logic                w_last;

    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_part;
    logic                r_carry;
    logic [c_cntw-1:0]   r_cnt;

    logic [CHUNK:0]      w_sum;
    logic [WIDTH-1:0]    w_sum_ext;
    logic [WIDTH-1:0]    w_next_part;
    logic                w_ovf;

    // Operand copies shift right so the active chunk always sits in the low
    // bits; the partial result fills from the top and is complete after N steps.
    assign w_last      = (r_cnt == c_last);
    assign w_sum       = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                       + (CHUNK+1)'(r_carry);
    assign w_sum_ext   = WIDTH'(w_sum[CHUNK-1:0]);
    assign w_next_part = (r_part >> CHUNK) | (w_sum_ext << (WIDTH - CHUNK));

    // On the final chunk the low bits of r_a/r_b hold the operand MSBs.
    assign w_ovf = (r_a[CHUNK-1] == r_b[CHUNK-1]) && (w_sum[CHUNK-1] != r_a[CHUNK-1]);

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                    w_accept     = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_next_state = S_RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            R       <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
            Zero    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B ^ {WIDTH{sub}};
            r_part  <= '0;
            r_carry <= sub;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_part  <= w_next_part;
            r_carry <= w_sum[CHUNK];
            if (w_last) begin
                R    <= w_next_part;
                Cout <= w_sum[CHUNK];
                Ovf  <= w_ovf;
                Zero <= (w_next_part == '0);
            end else begin
                r_cnt <= r_cnt + c_cntw'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_adder_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_adder_sub
// Purpose  : Self-checking bench for seq_adder_sub across five WIDTH/CHUNK
//            configurations against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_adder_sub;

    localparam int NC = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st  [NC];
    logic        sbx [NC];
    logic [31:0] av  [4];
    logic [31:0] bv  [4];
    logic [7:0]  a4, b4;
    logic        bz  [NC];
    logic        dn  [NC];
    logic        co  [NC];
    logic        ov  [NC];
    logic        zr  [NC];
    logic [31:0] rr  [4];
    logic [7:0]  r8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_adder_sub #(.WIDTH(32), .CHUNK(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sbx[0]), .A(av[0]), .B(bv[0]),
        .busy(bz[0]), .done(dn[0]), .R(rr[0]), .Cout(co[0]), .Ovf(ov[0]), .Zero(zr[0]));
    seq_adder_sub #(.WIDTH(32), .CHUNK(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sbx[1]), .A(av[1]), .B(bv[1]),
        .busy(bz[1]), .done(dn[1]), .R(rr[1]), .Cout(co[1]), .Ovf(ov[1]), .Zero(zr[1]));
    seq_adder_sub #(.WIDTH(32), .CHUNK(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sbx[2]), .A(av[2]), .B(bv[2]),
        .busy(bz[2]), .done(dn[2]), .R(rr[2]), .Cout(co[2]), .Ovf(ov[2]), .Zero(zr[2]));
    seq_adder_sub #(.WIDTH(32), .CHUNK(32)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .sub(sbx[3]), .A(av[3]), .B(bv[3]),
        .busy(bz[3]), .done(dn[3]), .R(rr[3]), .Cout(co[3]), .Ovf(ov[3]), .Zero(zr[3]));
    seq_adder_sub #(.WIDTH(8), .CHUNK(2)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st[4]), .sub(sbx[4]), .A(a4), .B(b4),
        .busy(bz[4]), .done(dn[4]), .R(r8), .Cout(co[4]), .Ovf(ov[4]), .Zero(zr[4]));

    function automatic int wof(input int c);
        return (c == 4) ? 8 : 32;
    endfunction

    function automatic int chof(input int c);
        case (c)
            0:       return 8;
            1:       return 1;
            2:       return 4;
            3:       return 32;
            default: return 2;
        endcase
    endfunction

    function automatic int nof(input int c);
        return wof(c) / chof(c);
    endfunction

    function automatic logic [31:0] get_r(input int c);
        return (c == 4) ? {24'h0, r8} : rr[c];
    endfunction

    // Reference: plain unsigned/signed integer arithmetic on W-bit values.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] r, output logic c,
                                  output logic o, output logic z);
        longint m, ua, ub, sa, sb, ur, sr;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        ur = s ? ua - ub : ua + ub;
        sr = s ? sa - sb : sa + sb;
        r  = 32'(((ur % m) + m) % m);
        c  = s ? (ua >= ub) : (ur >= m);
        o  = (sr < -(m / 2)) || (sr >= m / 2);
        z  = (r == 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int c, input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        if (c == 4) begin
            a4 = a[7:0];
            b4 = b[7:0];
        end else begin
            av[c] = a;
            bv[c] = b;
        end
        sbx[c] = s;
        st[c]  = 1'b1;
        @(posedge clk);
        #1;
        st[c] = 1'b0;
        chk("busy_after_start", 32'(bz[c]), 32'd1);
    endtask

    task automatic wait_done(input int c, output int lat, output int bcnt, output logic stable);
        logic [31:0] r0;
        r0     = get_r(c);
        lat    = 0;
        bcnt   = 0;
        stable = 1'b1;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (dn[c]) break;
            if (bz[c]) bcnt++;
            if (get_r(c) !== r0) stable = 1'b0;
        end
    endtask

    task automatic full_op(input int c, input logic [31:0] a, input logic [31:0] b, input logic s);
        int          lat, bc;
        logic        stable;
        logic [31:0] er;
        logic        ec, eo, ez;
        model(wof(c), a, b, s, er, ec, eo, ez);
        issue(c, a, b, s);
        wait_done(c, lat, bc, stable);
        chk("done_seen",    32'(dn[c]), 32'd1);
        chk("latency",      32'(lat), 32'(nof(c)));
        chk("busy_cycles",  32'(bc), 32'(nof(c) - 1));
        chk("busy_at_done", 32'(bz[c]), 32'd0);
        chk("hold_in_run",  32'(stable), 32'd1);
        chk("R",            get_r(c), er);
        chk("Cout",         32'(co[c]), 32'(ec));
        chk("Ovf",          32'(ov[c]), 32'(eo));
        chk("Zero",         32'(zr[c]), 32'(ez));
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(dn[c]), 32'd0);
    endtask

    initial begin
        int   lat, bc;
        logic stable, saw;

        for (int i = 0; i < NC; i++) begin
            st[i]  = 1'b0;
            sbx[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        a4 = '0;
        b4 = '0;

        // Reset state of every configuration.
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            chk("rst_busy", 32'(bz[c]), 32'd0);
            chk("rst_done", 32'(dn[c]), 32'd0);
            chk("rst_R",    get_r(c), 32'd0);
            chk("rst_flags", {29'd0, co[c], ov[c], zr[c]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        full_op(0, 32'h0000_0005, 32'h0000_0003, 1'b0);
        chk("t1_R", rr[0], 32'h0000_0008);
        chk("t1_flags", {29'd0, co[0], ov[0], zr[0]}, 32'd0);

        full_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        chk("t2_R", rr[0], 32'h0);
        chk("t2_flags", {29'd0, co[0], ov[0], zr[0]}, 32'b101);

        full_op(0, 32'd3, 32'd5, 1'b1);
        chk("t3a_R", rr[0], 32'hFFFF_FFFE);
        chk("t3a_Cout", 32'(co[0]), 32'd0);
        full_op(0, 32'h8000_0000, 32'd1, 1'b1);
        chk("t3b_R", rr[0], 32'h7FFF_FFFF);
        chk("t3b_flags", {30'd0, co[0], ov[0]}, 32'b11);
        full_op(0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        chk("t3c_R", rr[0], 32'h8000_0000);
        chk("t3c_Ovf", 32'(ov[0]), 32'd1);

        // start held high, operands scrambled while running.
        @(negedge clk);
        av[0] = 32'd5; bv[0] = 32'd3; sbx[0] = 1'b0; st[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_busy", 32'(bz[0]), 32'd1);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            av[0] = $urandom; bv[0] = $urandom; sbx[0] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
            if (dn[0]) break;
        end
        chk("hold_done_seen", 32'(dn[0]), 32'd1);
        chk("hold_latency", 32'(lat), 32'd4);
        chk("hold_R", rr[0], 32'h8);

        // Back-to-back start accepted in the DONE cycle.
        @(negedge clk);
        av[0] = 32'h10; bv[0] = 32'h20; sbx[0] = 1'b0;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        chk("b2b_busy", 32'(bz[0]), 32'd1);
        chk("b2b_done_low", 32'(dn[0]), 32'd0);
        wait_done(0, lat, bc, stable);
        chk("b2b_latency", 32'(lat), 32'd4);
        chk("b2b_R", rr[0], 32'h30);
        @(posedge clk);
        #1;

        // Asynchronous reset while chunk 2 is pending.
        issue(0, 32'h0000_1234, 32'h0000_1111, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bz[0]), 32'd0);
        chk("abort_done", 32'(dn[0]), 32'd0);
        chk("abort_R", rr[0], 32'd0);
        chk("abort_flags", {29'd0, co[0], ov[0], zr[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (dn[0]) saw = 1'b1;
        end
        chk("abort_no_done", 32'(saw), 32'd0);
        full_op(0, 32'h0000_1234, 32'h0000_1111, 1'b0);
        chk("abort_recover_R", rr[0], 32'h0000_2345);

        // Random sweep in every configuration.
        for (int c = 0; c < NC; c++) begin
            repeat (1000) full_op(c, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
